// File: rtl/gmii_mon_pkg.sv
// gmii_mon_pkg
//   Shared definitions for the GMII receive-side link monitor:
//   per-port FSM state encoding, Ethernet CRC-32 constants, preamble/SFD
//   byte values, error-flag bit positions and a byte-wide CRC-32 update.
package gmii_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } mon_state_e;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [2:0]  MAX_PRE     = 3'd7;

    // Error flag layout: {pre, rxer, giant, runt, crc}
    localparam int ERR_W     = 5;
    localparam int ERR_CRC   = 0;
    localparam int ERR_RUNT  = 1;
    localparam int ERR_GIANT = 2;
    localparam int ERR_RXER  = 3;
    localparam int ERR_PRE   = 4;

    // Reflected CRC-32 over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/gmii_mon_port.sv
// gmii_mon_port
//   Frame checker for a single GMII receive lane: preamble/SFD delineation,
//   CRC-32 residue check, length check, rxer tracking, saturating counters
//   and sticky error flags.
// Ports
//   clk, arst_n        byte clock, async active-low reset
//   rxd, rxdv, rxer    GMII lane
//   clr                sync clear of counters, last length and flags
//   ok_cnt, err_cnt    saturating good / errored frame counters
//   last_len           length of last completed frame (0 for preamble faults)
//   err_flags          sticky {pre, rxer, giant, runt, crc}
//   err_evt            one-cycle pulse when an errored frame is recorded
module gmii_mon_port
    import gmii_mon_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [7:0]       rxd,
    input  logic             rxdv,
    input  logic             rxer,
    input  logic             clr,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [15:0]      last_len,
    output logic [ERR_W-1:0] err_flags,
    output logic             err_evt
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

    mon_state_e       state_q, state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [15:0]      len_q, len_d;
    logic [31:0]      crc_q, crc_d;
    logic             rxer_q, rxer_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [15:0]      last_len_q, last_len_d;
    logic [ERR_W-1:0] flags_q, flags_d;

    logic             frame_end;
    logic [ERR_W-1:0] end_bits;
    logic [15:0]      end_len;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            len_q      <= '0;
            crc_q      <= CRC_INIT;
            rxer_q     <= 1'b0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            last_len_q <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            rxer_q     <= rxer_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
            last_len_q <= last_len_d;
            flags_q    <= flags_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rxdv) state_d = (rxd == PRE_BYTE) ? PRE : DROP;
            end
            PRE: begin
                if (!rxdv) begin
                    state_d = IDLE;
                end else if (rxd == PRE_BYTE) begin
                    // An eighth preamble byte is a fault.
                    if (pre_cnt_q == MAX_PRE) state_d = DROP;
                end else if (rxd == SFD_BYTE) begin
                    state_d = DATA;
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!rxdv) state_d = IDLE;
            end
            DROP: begin
                if (!rxdv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and statistics
    always_comb begin
        pre_cnt_d  = pre_cnt_q;
        len_d      = len_q;
        crc_d      = crc_q;
        rxer_d     = rxer_q;
        frame_end  = 1'b0;
        end_bits   = '0;
        end_len    = len_q;

        unique case (state_q)
            IDLE: begin
                if (rxdv) begin
                    pre_cnt_d = 3'd1;
                    rxer_d    = 1'b0;
                end
            end
            PRE: begin
                if (rxdv) begin
                    rxer_d = rxer_q | rxer;
                    if (rxd == PRE_BYTE && pre_cnt_q != MAX_PRE) begin
                        pre_cnt_d = pre_cnt_q + 3'd1;
                    end
                    if (rxd == SFD_BYTE) begin
                        crc_d = CRC_INIT;
                        len_d = '0;
                    end
                end else begin
                    frame_end          = 1'b1;
                    end_bits[ERR_PRE]  = 1'b1;
                    end_bits[ERR_RXER] = rxer_q;
                    end_len            = '0;
                end
            end
            DATA: begin
                if (rxdv) begin
                    crc_d  = crc32_byte(crc_q, rxd);
                    len_d  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                    rxer_d = rxer_q | rxer;
                end else begin
                    frame_end           = 1'b1;
                    end_bits[ERR_CRC]   = (crc_q != CRC_RESIDUE);
                    end_bits[ERR_RUNT]  = (len_q < MIN_LEN);
                    end_bits[ERR_GIANT] = (len_q > MAX_LEN);
                    end_bits[ERR_RXER]  = rxer_q;
                    end_len             = len_q;
                end
            end
            DROP: begin
                // Only reached through a preamble/SFD fault.
                if (!rxdv) begin
                    frame_end          = 1'b1;
                    end_bits[ERR_PRE]  = 1'b1;
                    end_bits[ERR_RXER] = rxer_q;
                    end_len            = '0;
                end
            end
            default: ;
        endcase
    end

    // Statistics update; clr overrides a coincident frame end.
    always_comb begin
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        last_len_d = last_len_q;
        flags_d    = flags_q;
        err_evt    = 1'b0;
        if (clr) begin
            ok_cnt_d   = '0;
            err_cnt_d  = '0;
            last_len_d = '0;
            flags_d    = '0;
        end else if (frame_end) begin
            last_len_d = end_len;
            if (end_bits == '0) begin
                if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + CNT_W'(1);
            end else begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                flags_d = flags_q | end_bits;
                err_evt = 1'b1;
            end
        end
    end

    assign ok_cnt    = ok_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign last_len  = last_len_q;
    assign err_flags = flags_q;

endmodule

// File: rtl/gmii_link_monitor.sv
// gmii_link_monitor
//   Passive multi-port GMII receive-side frame checker. One gmii_mon_port
//   per lane; this level adds the statistics readout mux and the sticky
//   halt request.
// Ports
//   clk, arst_n                    byte clock, async active-low reset
//   rxd, rxdv, rxer                GMII lanes, one entry per port
//   clr                            sync clear of all statistics and halt_req
//   rd_port                        statistics readout select
//   rd_ok_cnt, rd_err_cnt          frame counters of rd_port
//   rd_last_len, rd_err_flags      last length / sticky flags of rd_port
//   halt_req                       sticky request to stop the simulation
module gmii_link_monitor
    import gmii_mon_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int CNT_W       = 32,
    parameter int MIN_FRAME   = 64,
    parameter int MAX_FRAME   = 1518,
    parameter int HALT_ON_ERR = 1,
    localparam int RD_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [NUM_PORTS-1:0][7:0] rxd,
    input  logic [NUM_PORTS-1:0]      rxdv,
    input  logic [NUM_PORTS-1:0]      rxer,
    input  logic                      clr,
    input  logic [RD_W-1:0]           rd_port,
    output logic [CNT_W-1:0]          rd_ok_cnt,
    output logic [CNT_W-1:0]          rd_err_cnt,
    output logic [15:0]               rd_last_len,
    output logic [ERR_W-1:0]          rd_err_flags,
    output logic                      halt_req
);

    logic [CNT_W-1:0]     ok_cnt_a   [NUM_PORTS];
    logic [CNT_W-1:0]     err_cnt_a  [NUM_PORTS];
    logic [15:0]          last_len_a [NUM_PORTS];
    logic [ERR_W-1:0]     flags_a    [NUM_PORTS];
    logic [NUM_PORTS-1:0] err_evt;

    logic halt_q, halt_d;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        gmii_mon_port #(
            .CNT_W     (CNT_W),
            .MIN_FRAME (MIN_FRAME),
            .MAX_FRAME (MAX_FRAME)
        ) u_port (
            .clk       (clk),
            .arst_n    (arst_n),
            .rxd       (rxd[g]),
            .rxdv      (rxdv[g]),
            .rxer      (rxer[g]),
            .clr       (clr),
            .ok_cnt    (ok_cnt_a[g]),
            .err_cnt   (err_cnt_a[g]),
            .last_len  (last_len_a[g]),
            .err_flags (flags_a[g]),
            .err_evt   (err_evt[g])
        );
    end

    // Readout mux; an unpopulated port index reads as zero.
    always_comb begin
        rd_ok_cnt    = '0;
        rd_err_cnt   = '0;
        rd_last_len  = '0;
        rd_err_flags = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (int'(rd_port) == i) begin
                rd_ok_cnt    = ok_cnt_a[i];
                rd_err_cnt   = err_cnt_a[i];
                rd_last_len  = last_len_a[i];
                rd_err_flags = flags_a[i];
            end
        end
    end

    always_comb begin
        halt_d = halt_q;
        if (clr) begin
            halt_d = 1'b0;
        end else if (HALT_ON_ERR != 0 && |err_evt) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) halt_q <= 1'b0;
        else         halt_q <= halt_d;
    end

    assign halt_req = (HALT_ON_ERR != 0) ? halt_q : 1'b0;

endmodule

// File: tb/tb_gmii_link_monitor.sv
module tb_gmii_link_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: 4 ports, 32-bit counters
    logic            arst_n;
    logic [3:0][7:0] rxd;
    logic [3:0]      rxdv, rxer;
    logic            clr;
    logic [1:0]      rd_port;
    logic [31:0]     rd_ok_cnt, rd_err_cnt;
    logic [15:0]     rd_last_len;
    logic [4:0]      rd_err_flags;
    logic            halt_req;

    // Second DUT: 3 ports, 4-bit counters
    logic [2:0][7:0] rxd2;
    logic [2:0]      rxdv2, rxer2;
    logic            clr2;
    logic [1:0]      rd_port2;
    logic [3:0]      rd_ok2, rd_err2;
    logic [15:0]     rd_len2;
    logic [4:0]      rd_flags2;
    logic            halt2;

    gmii_link_monitor #(.NUM_PORTS(4), .CNT_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .rxd(rxd), .rxdv(rxdv), .rxer(rxer), .clr(clr),
        .rd_port(rd_port), .rd_ok_cnt(rd_ok_cnt), .rd_err_cnt(rd_err_cnt),
        .rd_last_len(rd_last_len), .rd_err_flags(rd_err_flags), .halt_req(halt_req)
    );

    gmii_link_monitor #(.NUM_PORTS(3), .CNT_W(4)) dut2 (
        .clk(clk), .arst_n(arst_n), .rxd(rxd2), .rxdv(rxdv2), .rxer(rxer2), .clr(clr2),
        .rd_port(rd_port2), .rd_ok_cnt(rd_ok2), .rd_err_cnt(rd_err2),
        .rd_last_len(rd_len2), .rd_err_flags(rd_flags2), .halt_req(halt2)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int         port;
        int         len;
        bit         bad;
        int         kind;
        int         rxer_at;
        logic [4:0] flags;
        logic [15:0] last_len;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] ok;
        logic [31:0] err;
        logic [15:0] len;
        logic [4:0]  flags;
        logic        halt;
    } exp_t;

    vec_t        tbl [14];
    exp_t        sb_q [$];
    logic [7:0]  seq_q [$];

    logic [31:0] m_ok   [4];
    logic [31:0] m_err  [4];
    logic [15:0] m_len  [4];
    logic [4:0]  m_fl   [4];
    logic        m_halt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // kind: 0 7x55+D5, 1 55,55,AA, 2 8x55+D5, 3 bare 0x12, 4 55,55 then carrier drop, 5 55+D5
    task automatic build_frame(input int n, input bit bad, input int kind);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        seq_q.delete();
        case (kind)
            0: begin repeat (7) seq_q.push_back(8'h55); seq_q.push_back(8'hD5); end
            1: begin seq_q.push_back(8'h55); seq_q.push_back(8'h55); seq_q.push_back(8'hAA); end
            2: begin repeat (8) seq_q.push_back(8'h55); seq_q.push_back(8'hD5); end
            3: seq_q.push_back(8'h12);
            4: begin seq_q.push_back(8'h55); seq_q.push_back(8'h55); return; end
            default: begin seq_q.push_back(8'h55); seq_q.push_back(8'hD5); end
        endcase
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < n - 4; i++) begin
            b = 8'($urandom);
            seq_q.push_back(b);
            crc = crc_upd(crc, b);
        end
        fcs = ~crc;
        seq_q.push_back(fcs[7:0]);
        seq_q.push_back(fcs[15:8]);
        seq_q.push_back(fcs[23:16]);
        seq_q.push_back(fcs[31:24]);
        if (bad) seq_q[seq_q.size()-1] = seq_q[seq_q.size()-1] ^ 8'h01;
    endtask

    task automatic idle_inputs();
        rxd = '0; rxdv = '0; rxer = '0;
        rxd2 = '0; rxdv2 = '0; rxer2 = '0;
    endtask

    task automatic send(input int tgt, input logic [3:0] mask, input int rxer_at, input bit clr_end);
        for (int i = 0; i < seq_q.size(); i++) begin
            for (int p = 0; p < 4; p++) begin
                if (tgt == 0) begin
                    rxd[p]  = mask[p] ? seq_q[i] : 8'h00;
                    rxdv[p] = mask[p];
                    rxer[p] = mask[p] && (i == rxer_at);
                end else if (p < 3) begin
                    rxd2[p]  = mask[p] ? seq_q[i] : 8'h00;
                    rxdv2[p] = mask[p];
                    rxer2[p] = mask[p] && (i == rxer_at);
                end
            end
            tick();
        end
        idle_inputs();
        clr = clr_end;
        tick();
        clr = 1'b0;
        repeat (11) tick();
    endtask

    task automatic observe(input int port, input logic [31:0] prev_sum);
        exp_t e;
        int   t;
        rd_port = 2'(port);
        #1;
        t = 0;
        while (rd_ok_cnt + rd_err_cnt == prev_sum && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_miss++;
            $display("FAIL frame_end_timeout port %0d: count stuck at %0d expected change", port, prev_sum);
        end
        e = sb_q.pop_front();
        chk($sformatf("ok_cnt p%0d", e.port), rd_ok_cnt, e.ok);
        chk($sformatf("err_cnt p%0d", e.port), rd_err_cnt, e.err);
        chk($sformatf("last_len p%0d", e.port), 32'(rd_last_len), 32'(e.len));
        chk($sformatf("err_flags p%0d", e.port), 32'(rd_err_flags), 32'(e.flags));
        chk("halt_req", 32'(halt_req), 32'(m_halt));
    endtask

    task automatic check_all_zero(input string tag);
        for (int p = 0; p < 4; p++) begin
            rd_port = 2'(p);
            #1;
            chk($sformatf("%s ok p%0d", tag, p), rd_ok_cnt, 32'd0);
            chk($sformatf("%s err p%0d", tag, p), rd_err_cnt, 32'd0);
            chk($sformatf("%s len p%0d", tag, p), 32'(rd_last_len), 32'd0);
            chk($sformatf("%s flags p%0d", tag, p), 32'(rd_err_flags), 32'd0);
        end
        chk($sformatf("%s halt", tag), 32'(halt_req), 32'd0);
    endtask

    task automatic model_clear();
        for (int p = 0; p < 4; p++) begin
            m_ok[p] = '0; m_err[p] = '0; m_len[p] = '0; m_fl[p] = '0;
        end
        m_halt = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [31:0] prev;
        int          p;

        tbl[0]  = '{0,   64, 1'b0, 0, -1, 5'b00000, 16'd64};
        tbl[1]  = '{0,   64, 1'b1, 0, -1, 5'b00001, 16'd64};
        tbl[2]  = '{1,   40, 1'b0, 0, -1, 5'b00010, 16'd40};
        tbl[3]  = '{2, 1600, 1'b0, 0, -1, 5'b00100, 16'd1600};
        tbl[4]  = '{3,   64, 1'b0, 0, 28, 5'b01000, 16'd64};
        tbl[5]  = '{1,   64, 1'b0, 1, -1, 5'b10000, 16'd0};
        tbl[6]  = '{2,   64, 1'b0, 2, -1, 5'b10000, 16'd0};
        tbl[7]  = '{3,   64, 1'b0, 3, -1, 5'b10000, 16'd0};
        tbl[8]  = '{0,   64, 1'b0, 4, -1, 5'b10000, 16'd0};
        tbl[9]  = '{1, 1518, 1'b0, 0, -1, 5'b00000, 16'd1518};
        tbl[10] = '{2,   63, 1'b0, 0, -1, 5'b00010, 16'd63};
        tbl[11] = '{3,   64, 1'b0, 5, -1, 5'b00000, 16'd64};
        tbl[12] = '{0, 1519, 1'b0, 0, -1, 5'b00100, 16'd1519};
        tbl[13] = '{1,   64, 1'b0, 0,  3, 5'b01000, 16'd64};

        arst_n = 1'b0;
        clr = 1'b0; clr2 = 1'b0;
        rd_port = '0; rd_port2 = '0;
        idle_inputs();
        model_clear();
        repeat (3) tick();
        arst_n = 1'b1;
        tick();

        check_all_zero("reset");

        // Table-driven single-frame vectors
        for (int r = 0; r < 14; r++) begin
            p = tbl[r].port;
            build_frame(tbl[r].len, tbl[r].bad, tbl[r].kind);
            prev = m_ok[p] + m_err[p];
            if (tbl[r].flags == 5'b0) m_ok[p]++;
            else begin
                m_err[p]++;
                m_fl[p] = m_fl[p] | tbl[r].flags;
                m_halt = 1'b1;
            end
            m_len[p] = tbl[r].last_len;
            e = '{p, m_ok[p], m_err[p], m_len[p], m_fl[p], m_halt};
            sb_q.push_back(e);
            send(0, 4'(1 << p), tbl[r].rxer_at, 1'b0);
            observe(p, prev);
        end

        // Good frames ending in the same cycle on every port
        build_frame(64, 1'b0, 0);
        send(0, 4'hF, -1, 1'b0);
        for (int q = 0; q < 4; q++) begin
            m_ok[q]++;
            m_len[q] = 16'd64;
            rd_port = 2'(q);
            #1;
            chk($sformatf("simul ok p%0d", q), rd_ok_cnt, m_ok[q]);
            chk($sformatf("simul len p%0d", q), 32'(rd_last_len), 32'd64);
        end

        // clr coincident with a frame end discards that frame
        build_frame(64, 1'b1, 0);
        send(0, 4'h1, -1, 1'b1);
        model_clear();
        check_all_zero("clr");

        // Monitor keeps working after clr
        build_frame(64, 1'b0, 0);
        send(0, 4'h1, -1, 1'b0);
        rd_port = 2'd0;
        #1;
        chk("post_clr ok p0", rd_ok_cnt, 32'd1);

        // Async reset in the middle of a frame on port 2
        build_frame(64, 1'b0, 0);
        for (int i = 0; i < 30; i++) begin
            rxd[2] = seq_q[i];
            rxdv[2] = 1'b1;
            tick();
        end
        arst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        arst_n = 1'b1;
        repeat (2) tick();
        model_clear();
        check_all_zero("mid_reset");

        build_frame(64, 1'b0, 0);
        send(0, 4'h4, -1, 1'b0);
        rd_port = 2'd2;
        #1;
        chk("post_reset ok p2", rd_ok_cnt, 32'd1);
        chk("post_reset len p2", 32'(rd_last_len), 32'd64);
        chk("post_reset err p2", rd_err_cnt, 32'd0);

        // Counter saturation on the 4-bit instance
        for (int k = 0; k < 20; k++) begin
            build_frame(64, 1'b0, 0);
            send(1, 4'h1, -1, 1'b0);
        end
        rd_port2 = 2'd0;
        #1;
        chk("sat ok p0", 32'(rd_ok2), 32'hF);
        chk("sat err p0", 32'(rd_err2), 32'h0);
        chk("sat halt", 32'(halt2), 32'h0);
        rd_port2 = 2'd3;
        #1;
        chk("oob ok", 32'(rd_ok2), 32'h0);
        chk("oob len", 32'(rd_len2), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
